// File: rtl/sort_pkg.sv
// Shared types and helpers for the streaming insertion sorter.
package sort_pkg;

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned seq_len);
    return $clog2(seq_len + 1);
  endfunction

  // True when a sits at or before b in emit order.
  function automatic logic ordered_before(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        desc);
    return desc ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/sort_insert_cell.sv
// One slot of the insertion array: decides keep / take new / shift up.
module sort_insert_cell
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] i_new,
  input  logic [DATA_WIDTH-1:0] i_own,
  input  logic [DATA_WIDTH-1:0] i_lower,
  input  logic                  i_occupied,
  input  logic                  i_lower_flag,
  output logic [DATA_WIDTH-1:0] o_next,
  output logic                  o_flag
);

  // Flag: the new element lands at this slot or below it.
  assign o_flag = i_lower_flag ||
                  !(i_occupied && ordered_before(64'(i_own), 64'(i_new), DESCENDING));

  always_comb begin
    o_next = i_own;
    if (o_flag) begin
      o_next = i_lower_flag ? i_lower : i_new;
    end
  end

endmodule

// File: rtl/seq_sorter_n.sv
// Streaming sorter: insertion-sorts SEQ_LEN elements, then emits them in order.
module seq_sorter_n
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEQ_LEN    = 4,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] max,
  output logic                  max_valid,
  output logic                  busy
);

  localparam int unsigned    CW       = cnt_width(SEQ_LEN);
  localparam logic [CW-1:0]  LAST_IDX = CW'(SEQ_LEN - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_idx;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_arr [SEQ_LEN];
  logic [DATA_WIDTH-1:0] r_run_max;
  logic [DATA_WIDTH-1:0] r_max;
  logic                  r_max_valid;

  logic [DATA_WIDTH-1:0] w_next [SEQ_LEN];
  logic [SEQ_LEN-1:0]    w_ge;
  logic [DATA_WIDTH-1:0] w_run_next;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  w_accept;

  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_cell
    logic [DATA_WIDTH-1:0] w_lower;
    logic                  w_lower_flag;
    if (i == 0) begin : g_first
      assign w_lower      = '0;
      assign w_lower_flag = 1'b0;
    end else begin : g_rest
      assign w_lower      = r_arr[i-1];
      assign w_lower_flag = w_ge[i-1];
    end
    sort_insert_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .DESCENDING (DESCENDING)
    ) u_cell (
      .i_new        (in_data),
      .i_own        (r_arr[i]),
      .i_lower      (w_lower),
      .i_occupied   (CW'(i) < r_cnt),
      .i_lower_flag (w_lower_flag),
      .o_next       (w_next[i]),
      .o_flag       (w_ge[i])
    );
  end

  // The top cell's flag doubles as the array-has-room check.
  assign w_accept   = in_valid && (r_state == LOAD) && w_ge[SEQ_LEN-1];
  assign w_run_next = ((r_cnt == '0) || (in_data > r_run_max)) ? in_data : r_run_max;

  always_comb begin
    w_out = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (r_idx == CW'(i)) w_out = r_arr[i];
    end
  end

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_data  = w_out;
  assign out_last  = r_last;
  assign max       = r_max;
  assign max_valid = r_max_valid;
  assign busy      = (r_cnt != '0) || (r_state == EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_run_max   <= '0;
      r_max       <= '0;
      r_max_valid <= 1'b0;
      for (int unsigned i = 0; i < SEQ_LEN; i++) r_arr[i] <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            for (int unsigned i = 0; i < SEQ_LEN; i++) r_arr[i] <= w_next[i];
            r_run_max <= w_run_next;
            if (r_cnt == LAST_IDX) begin
              r_cnt       <= '0;
              r_idx       <= '0;
              r_last      <= 1'b0;
              r_max       <= w_run_next;
              r_max_valid <= 1'b1;
              r_state     <= EMIT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_last) begin
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_state <= LOAD;
            end else begin
              r_idx  <= r_idx + CW'(1);
              r_last <= ((r_idx + CW'(1)) == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule
